// File: rtl/load_store_unit.sv
// RV32I load/store unit: aligns and extends loads, lane-replicates stores,
// flags misaligned or undefined accesses, and runs one access at a time.
module load_store_unit #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_misaligned,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESPOND} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  logic        lat_we;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  cnt_q;
  logic [31:0] rdata_q;
  logic        mis_q;

  logic        accept;
  logic        fault;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_ext;
  logic [31:0] store_data;
  logic [3:0]  store_strb;

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // Fault check is on the incoming request so a bad access never reaches memory.
  always_comb begin
    fault = 1'b0;
    if (req_we)
      fault = (req_funct3 > 3'b010);
    else
      fault = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
    if ((req_funct3[1:0] == 2'b01) && req_addr[0])
      fault = 1'b1;
    if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))
      fault = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = fault ? RESPOND : ACCESS;
      ACCESS:  state_d = lat_we ? RESPOND : WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESPOND;
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_byte = mem_rdata[7:0];
    case (lat_addr[1:0])
      2'b00:   sel_byte = mem_rdata[7:0];
      2'b01:   sel_byte = mem_rdata[15:8];
      2'b10:   sel_byte = mem_rdata[23:16];
      default: sel_byte = mem_rdata[31:24];
    endcase
    sel_half = lat_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lat_funct3)
      3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  load_ext = {24'h0, sel_byte};
      3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
      3'b101:  load_ext = {16'h0, sel_half};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    case (lat_funct3[1:0])
      2'b00: begin
        store_data = {4{lat_wdata[7:0]}};
        store_strb = 4'b0001 << lat_addr[1:0];
      end
      2'b01: begin
        store_data = {2{lat_wdata[15:0]}};
        store_strb = lat_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_data = lat_wdata;
        store_strb = 4'b1111;
      end
    endcase
  end

  // Memory side is quiet (all zero) outside the single ACCESS cycle.
  assign mem_en         = (state_q == ACCESS);
  assign mem_we         = mem_en && lat_we;
  assign mem_addr       = mem_en ? {lat_addr[31:2], 2'b00} : 32'h0;
  assign mem_wdata      = mem_we ? store_data : 32'h0;
  assign mem_wstrb      = mem_we ? store_strb : 4'h0;
  assign rsp_valid      = (state_q == RESPOND);
  assign rsp_rdata      = rdata_q;
  assign rsp_misaligned = mis_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lat_we     <= 1'b0;
      lat_funct3 <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rdata_q    <= '0;
      mis_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            lat_we     <= req_we;
            lat_funct3 <= req_funct3;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            if (fault) begin
              rdata_q <= '0;
              mis_q   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          cnt_q <= CNT_INIT;
          if (lat_we) begin
            rdata_q <= '0;
            mis_q   <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            rdata_q <= load_ext;
            mis_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (MEM_LATENCY 1 and 3), a delayed-read
// memory model, and an arithmetic reference model of RV32I load/store rules.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_misaligned [2];
  logic        mem_en [2];
  logic        mem_we [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_wstrb [2];
  logic [31:0] mem_rdata [2];

  logic [31:0] tb_mem [256];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic        pipe_en [16];
    logic [31:0] pipe_addr [16];
    logic [31:0] noise;

    load_store_unit #(.MEM_LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
      .req_funct3(req_funct3[g]), .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]), .rsp_misaligned(rsp_misaligned[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_wstrb(mem_wstrb[g]), .mem_rdata(mem_rdata[g])
    );

    // Read data is valid only LAT cycles after the enable cycle; noise otherwise.
    always @(posedge clk) begin
      pipe_en[0]   <= mem_en[g] && !mem_we[g];
      pipe_addr[0] <= mem_addr[g];
      for (int i = 1; i < 16; i++) begin
        pipe_en[i]   <= pipe_en[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
      noise <= $urandom;
    end
    assign mem_rdata[g] = pipe_en[LAT-1] ? tb_mem[pipe_addr[LAT-1][9:2]] : noise;
  end

  typedef struct {
    int lat; int en_cnt; logic we; logic [31:0] addr; logic [31:0] wdata;
    logic [3:0] wstrb; logic [31:0] rdata; logic mis; int gate_err; int busy_ready; logic post_ok;
  } obs_t;

  typedef struct {
    int lat; int en_cnt; logic [31:0] addr; logic [31:0] wdata;
    logic [3:0] wstrb; logic [31:0] rdata; logic mis;
  } exp_t;

  function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int lat);
    exp_t e;
    logic [31:0] word, b, h;
    int width;
    bit bad;
    e = '{default: 0};
    word  = tb_mem[addr[9:2]];
    width = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    bad   = we ? (f3 > 2) : (f3 == 3 || f3 == 6 || f3 == 7);
    if (addr % width != 0) bad = 1;
    if (bad) begin
      e.lat = 1; e.mis = 1'b1;
      return e;
    end
    e.en_cnt = 1;
    e.addr   = addr - (addr % 4);
    b = (word >> (8 * (addr % 4))) % 256;
    h = (word >> (16 * ((addr % 4) / 2))) % 65536;
    if (we) begin
      e.lat = 2;
      if (width == 1) begin
        e.wdata = (wdata % 256) * 32'h0101_0101; e.wstrb = 4'(1 << (addr % 4));
      end else if (width == 2) begin
        e.wdata = (wdata % 65536) * 32'h0001_0001; e.wstrb = (addr % 4 == 2) ? 4'b1100 : 4'b0011;
      end else begin
        e.wdata = wdata; e.wstrb = 4'b1111;
      end
    end else begin
      e.lat = 2 + lat;
      case (f3)
        3'd0: e.rdata = (b >= 128) ? b - 32'd256 : b;
        3'd4: e.rdata = b;
        3'd1: e.rdata = (h >= 32768) ? h - 32'd65536 : h;
        3'd5: e.rdata = h;
        default: e.rdata = word;
      endcase
    end
    return e;
  endfunction

  // Runs one request from the accept edge to the cycle after the response.
  task automatic do_req(input int idx, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit hold, output obs_t o);
    int t;
    o = '{default: 0};
    o.lat = -1;
    t = 0;
    while (!req_ready[idx] && t < 50) begin
      @(negedge clk);
      t++;
    end
    req_valid[idx] = 1'b1; req_we[idx] = we; req_funct3[idx] = f3;
    req_addr[idx] = addr; req_wdata[idx] = wdata;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (!hold) req_valid[idx] = 1'b0;
        else begin
          req_we[idx] = 1'($urandom); req_funct3[idx] = 3'($urandom);
          req_addr[idx] = $urandom; req_wdata[idx] = $urandom;
        end
      end
      if (mem_en[idx]) begin
        o.en_cnt++; o.we = mem_we[idx]; o.addr = mem_addr[idx];
        o.wdata = mem_wdata[idx]; o.wstrb = mem_wstrb[idx];
      end else if (mem_we[idx] || mem_wstrb[idx] != 4'h0 || mem_wdata[idx] != 32'h0) o.gate_err++;
      if (req_ready[idx]) o.busy_ready++;
      if (rsp_valid[idx]) begin
        o.lat = k; o.rdata = rsp_rdata[idx]; o.mis = rsp_misaligned[idx];
        break;
      end
    end
    @(negedge clk);
    o.post_ok = req_ready[idx] && !rsp_valid[idx] && rsp_rdata[idx] === o.rdata
                && rsp_misaligned[idx] === o.mis;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_funct3[i] = 3'd0;
      req_addr[i] = 32'h0; req_wdata[i] = 32'h0;
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if ({req_ready[i], rsp_valid[i], rsp_misaligned[i], mem_en[i], mem_we[i]} !== 5'b0 ||
          rsp_rdata[i] !== 32'h0 || mem_addr[i] !== 32'h0 || mem_wdata[i] !== 32'h0 || mem_wstrb[i] !== 4'h0) begin
        n_err++;
        $display("[TB] FAIL reset_outputs[%0d]: got ready=%b valid=%b en=%b rdata=%h, want all 0",
                 i, req_ready[i], rsp_valid[i], mem_en[i], rsp_rdata[i]);
      end
    end
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (req_ready[i] !== 1'b1) begin
        n_err++; $display("[TB] FAIL reset_ready[%0d]: got %b want 1", i, req_ready[i]);
      end
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [5]   = '{3'd2, 3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] addrs [5] = '{32'ha8, 32'hab, 32'hab, 32'haa, 32'ha8};
    logic [31:0] wants [5] = '{32'hdeadbeef, 32'hffffffde, 32'h000000de, 32'hffffdead, 32'h0000beef};
    obs_t o;
    for (int i = 0; i < 5; i++) begin
      do_req(0, 1'b0, f3s[i], addrs[i], 32'h0, 1'b0, o);
      n_vec++; if (o.rdata !== wants[i]) begin n_err++; $display("[TB] FAIL load%0d_rdata: got %h want %h", i, o.rdata, wants[i]); end
      n_vec++; if (o.lat !== 3) begin n_err++; $display("[TB] FAIL load%0d_lat: got %0d want 3", i, o.lat); end
      n_vec++; if (o.en_cnt !== 1 || o.addr !== 32'ha8 || o.we !== 1'b0) begin
        n_err++; $display("[TB] FAIL load%0d_mem: got en=%0d addr=%h we=%b want 1 a8 0", i, o.en_cnt, o.addr, o.we);
      end
      n_vec++; if (o.mis !== 1'b0) begin n_err++; $display("[TB] FAIL load%0d_mis: got %b want 0", i, o.mis); end
    end
  endtask

  task automatic test_stores();
    logic [2:0]  f3s [3]    = '{3'd0, 3'd1, 3'd2};
    logic [31:0] addrs [3]  = '{32'ha1, 32'ha2, 32'ha4};
    logic [31:0] wdatas [3] = '{32'h78787878, 32'h56785678, 32'h12345678};
    logic [3:0]  strbs [3]  = '{4'b0010, 4'b1100, 4'b1111};
    obs_t o;
    for (int i = 0; i < 3; i++) begin
      do_req(0, 1'b1, f3s[i], addrs[i], 32'h12345678, 1'b0, o);
      n_vec++; if (o.lat !== 2) begin n_err++; $display("[TB] FAIL store%0d_lat: got %0d want 2", i, o.lat); end
      n_vec++; if (o.wstrb !== strbs[i] || o.wdata !== wdatas[i]) begin
        n_err++; $display("[TB] FAIL store%0d_lanes: got strb=%b wdata=%h want %b %h", i, o.wstrb, o.wdata, strbs[i], wdatas[i]);
      end
      n_vec++; if (o.addr !== (addrs[i] & 32'hfffffffc) || o.we !== 1'b1 || o.en_cnt !== 1) begin
        n_err++; $display("[TB] FAIL store%0d_mem: got addr=%h we=%b en=%0d", i, o.addr, o.we, o.en_cnt);
      end
      n_vec++; if (o.rdata !== 32'h0 || o.gate_err !== 0) begin
        n_err++; $display("[TB] FAIL store%0d_quiet: got rdata=%h gate_err=%0d want 0 0", i, o.rdata, o.gate_err);
      end
    end
  endtask

  task automatic test_faults();
    logic        wes [4]   = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3s [4]   = '{3'd2, 3'd1, 3'd3, 3'd4};
    logic [31:0] addrs [4] = '{32'ha6, 32'ha3, 32'ha8, 32'ha8};
    obs_t o;
    for (int i = 0; i < 4; i++) begin
      do_req(0, wes[i], f3s[i], addrs[i], 32'hffffffff, 1'b0, o);
      n_vec++; if (o.lat !== 1 || o.mis !== 1'b1) begin
        n_err++; $display("[TB] FAIL fault%0d_rsp: got lat=%0d mis=%b want 1 1", i, o.lat, o.mis);
      end
      n_vec++; if (o.en_cnt !== 0 || o.rdata !== 32'h0) begin
        n_err++; $display("[TB] FAIL fault%0d_mem: got en=%0d rdata=%h want 0 0", i, o.en_cnt, o.rdata);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    do_req(1, 1'b0, 3'd2, 32'hac, 32'h0, 1'b1, o1);
    do_req(1, 1'b0, 3'd1, 32'hae, 32'h0, 1'b0, o2);
    n_vec++; if (o1.lat !== 5 || o1.rdata !== 32'hcafebabe) begin
      n_err++; $display("[TB] FAIL lat3_lw: got lat=%0d rdata=%h want 5 cafebabe", o1.lat, o1.rdata);
    end
    n_vec++; if (o1.busy_ready !== 0 || o1.en_cnt !== 1 || !o1.post_ok) begin
      n_err++; $display("[TB] FAIL lat3_busy: got busy_ready=%0d en=%0d post_ok=%b want 0 1 1", o1.busy_ready, o1.en_cnt, o1.post_ok);
    end
    n_vec++; if (o2.lat !== 5 || o2.rdata !== 32'hffffcafe) begin
      n_err++; $display("[TB] FAIL b2b_second: got lat=%0d rdata=%h want 5 ffffcafe", o2.lat, o2.rdata);
    end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic we;
    logic [2:0] f3;
    logic [31:0] addr, wdata;
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 2; i++) begin
        we = 1'($urandom); f3 = 3'($urandom); addr = $urandom; wdata = $urandom;
        e = model(we, f3, addr, wdata, (i == 0) ? 1 : 3);
        do_req(i, we, f3, addr, wdata, 1'b0, o);
        n_vec++;
        if (o.lat !== e.lat || o.en_cnt !== e.en_cnt || o.rdata !== e.rdata || o.mis !== e.mis ||
            (e.en_cnt == 1 && (o.addr !== e.addr || o.we !== we)) ||
            (e.en_cnt == 1 && we && (o.wdata !== e.wdata || o.wstrb !== e.wstrb)) ||
            o.gate_err !== 0 || o.busy_ready !== 0 || !o.post_ok) begin
          n_err++;
          $display("[TB] FAIL rand[%0d] we=%b f3=%0d addr=%h: got lat=%0d en=%0d rdata=%h mis=%b strb=%b wd=%h want lat=%0d en=%0d rdata=%h mis=%b strb=%b wd=%h",
                   i, we, f3, addr, o.lat, o.en_cnt, o.rdata, o.mis, o.wstrb, o.wdata,
                   e.lat, e.en_cnt, e.rdata, e.mis, e.wstrb, e.wdata);
        end
      end
    end
  endtask

  task automatic test_reset_in_wait();
    int seen;
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_funct3[1] = 3'd2; req_addr[1] = 32'hac;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({req_ready[1], rsp_valid[1], rsp_misaligned[1], mem_en[1], mem_we[1]} !== 5'b0 ||
        rsp_rdata[1] !== 32'h0 || mem_addr[1] !== 32'h0 || mem_wdata[1] !== 32'h0 || mem_wstrb[1] !== 4'h0) begin
      n_err++; $display("[TB] FAIL wait_reset_outputs: got valid=%b en=%b rdata=%h ready=%b, want all 0",
                        rsp_valid[1], mem_en[1], rsp_rdata[1], req_ready[1]);
    end
    reset = 1'b0;
    #1;
    n_vec++; if (req_ready[1] !== 1'b1) begin n_err++; $display("[TB] FAIL wait_reset_ready: got %b want 1", req_ready[1]); end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid[1] || mem_en[1]) seen++;
    end
    n_vec++; if (seen !== 0) begin n_err++; $display("[TB] FAIL wait_reset_abort: got %0d stray cycles want 0", seen); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = $urandom;
    tb_mem[32'ha8 >> 2] = 32'hdeadbeef;
    tb_mem[32'hac >> 2] = 32'hcafebabe;
    test_reset();
    test_loads();
    test_stores();
    test_faults();
    test_back_to_back();
    test_random();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: MEM_LATENCY, default 1, cycles from memory-enable cycle to valid mem_rdata (legal 1..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: req_valid  input  1  core requests a load/store this cycle.
REQ-005 SHALL have port: req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port: req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: req_funct3  input  3  RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-008 SHALL have port: req_addr  input  32  byte address (ALU result).
REQ-009 SHALL have port: req_wdata  input  32  store data, rs2 value.
REQ-010 SHALL have port: rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: rsp_rdata  output  32  extended load data; 0 for stores and faults.
REQ-012 SHALL have port: rsp_misaligned  output  1  request faulted; valid with rsp_valid.
REQ-013 SHALL have port: mem_en  output  1  memory access strobe, exactly one cycle per access.
REQ-014 SHALL have port: mem_we  output  1  write enable, qualified by mem_en.
REQ-015 SHALL have port: mem_addr  output  32  word-aligned address, {req_addr[31:2],2'b00}.
REQ-016 SHALL have port: mem_wdata  output  32  lane-replicated store data.
REQ-017 SHALL have port: mem_wstrb  output  4  byte write strobes; bit i = byte lane i.
REQ-018 SHALL have port: mem_rdata  input  32  read word from memory.

Function
REQ-019 SHALL implement states IDLE, ACCESS, WAIT, RESPOND; req_ready = 1 only in IDLE with reset low.
REQ-020 SHALL accept a request on a rising edge with req_valid & req_ready, latching we, funct3, addr, wdata; req_valid outside IDLE is ignored.
REQ-021 SHALL flag misaligned: halfword with addr[0]=1, word with addr[1:0]!=0, or undefined funct3 (load 3'b011/110/111, store >3'b010); such a request goes IDLE->RESPOND with rsp_misaligned=1 and no mem_en.
REQ-022 SHALL otherwise go IDLE->ACCESS; ACCESS drives mem_en=1 for one cycle with mem_we, mem_addr, mem_wdata, mem_wstrb from the latched request.
REQ-023 SHALL go ACCESS->RESPOND for stores and ACCESS->WAIT for loads, loading a counter with MEM_LATENCY-1.
REQ-024 SHALL in WAIT decrement the counter each cycle and, when it is 0, register the extended mem_rdata and go to RESPOND.
REQ-025 SHALL in RESPOND assert rsp_valid for exactly one cycle, then return to IDLE; back-to-back requests are accepted from that IDLE cycle.
REQ-026 SHALL give latency from accept edge to rsp_valid: load 2+MEM_LATENCY cycles, store 2, fault 1.
REQ-027 SHALL extend loads: LB/LBU select byte addr[1:0], sign/zero-extended; LH/LHU select halfword addr[1], sign/zero-extended; LW passes the word.
REQ-028 SHALL form stores: SB wdata={4{wdata[7:0]}}, wstrb=4'b0001<<addr[1:0]; SH wdata={2{wdata[15:0]}}, wstrb=addr[1]?4'b1100:4'b0011; SW wdata unchanged, wstrb=4'b1111.
REQ-029 SHALL drive mem_we, mem_wstrb and mem_wdata to 0 whenever mem_en=0.
REQ-030 SHALL hold rsp_rdata and rsp_misaligned stable from RESPOND until the next RESPOND.

Reset
REQ-031 SHALL on reset high at a rising edge enter IDLE, clear the counter, and drive rsp_valid, rsp_rdata, rsp_misaligned, mem_en, mem_we, mem_wstrb, mem_wdata, mem_addr to 0.
REQ-032 SHALL abort any in-flight access on reset: no rsp_valid for that request, and no mem_en after the reset edge.
REQ-033 SHALL hold req_ready=0 while reset is high; it SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-034 SHALL cover: LW addr 0xa8, mem word 0xdeadbeef, MEM_LATENCY=1 -> one mem_en, mem_addr 0xa8, mem_we 0, rsp_valid 3 cycles after accept, rsp_rdata 0xdeadbeef, rsp_misaligned 0.
REQ-035 SHALL cover: mem word 0xdeadbeef at 0xa8: LB 0xab -> 0xffffffde; LBU 0xab -> 0x000000de; LH 0xaa -> 0xffffdead; LHU 0xa8 -> 0x0000beef.
REQ-036 SHALL cover: SB addr 0xa1 wdata 0x12345678 -> mem_addr 0xa0, mem_wstrb 4'b0010, mem_wdata 0x78787878, rsp_valid 2 cycles after accept; SH addr 0xa2 -> mem_wstrb 4'b1100, mem_wdata 0x56785678.
REQ-037 SHALL cover: LW addr 0xa6 and SH addr 0xa3 -> no mem_en, rsp_valid 1 cycle after accept, rsp_misaligned 1, rsp_rdata 0.
REQ-038 SHALL cover: MEM_LATENCY=3, LW 0xac (0xcafebabe) with req_valid held high throughout -> rsp_valid 5 cycles after accept, rsp_rdata 0xcafebabe, second request accepted only after return to IDLE.
REQ-039 SHALL cover: reset asserted during WAIT -> no rsp_valid, all outputs 0 the next cycle, req_ready 1 the first cycle after reset deasserts.
